// File: rtl/id_stage_sb.sv
// Decode stage: handshaked ID register, 3-read regfile with PC alias
// and writeback bypass, per-register pending-write scoreboard.
module id_stage_sb #(
  parameter int XLEN    = 32,
  parameter int NREG    = 16,
  parameter int PC_IDX  = 15,
  parameter int MAXPEND = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_instr,
  input  logic [XLEN-1:0]         in_pcplus8,
  input  logic [$clog2(NREG)-1:0] in_ra1,
  input  logic [$clog2(NREG)-1:0] in_ra2,
  input  logic [$clog2(NREG)-1:0] in_ra3,
  input  logic [2:0]              in_use,
  input  logic [$clog2(NREG)-1:0] in_wa,
  input  logic                    in_we,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_instr,
  output logic [XLEN-1:0]         out_pcplus8,
  output logic [XLEN-1:0]         out_rd1,
  output logic [XLEN-1:0]         out_rd2,
  output logic [XLEN-1:0]         out_rd3,
  input  logic                    wb_en,
  input  logic [$clog2(NREG)-1:0] wb_addr,
  input  logic [XLEN-1:0]         wb_data,
  input  logic                    kill_en,
  input  logic [$clog2(NREG)-1:0] kill_addr,
  input  logic                    flush
);

  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(MAXPEND+1);
  localparam logic [AW-1:0] PCA = AW'(PC_IDX);
  localparam logic [CW-1:0] PMAX = CW'(MAXPEND);

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [AW-1:0]   ra1;
    logic [AW-1:0]   ra2;
    logic [AW-1:0]   ra3;
    logic [2:0]      srcuse;
    logic [AW-1:0]   wa;
    logic            we;
  } ent_t;

  ent_t            ent_q, ent_d;
  logic            vld_q, vld_d;
  logic [XLEN-1:0] rf_q   [NREG];
  logic [CW-1:0]   pend_q [NREG];
  logic [CW-1:0]   pend_d [NREG];

  logic [AW-1:0]   ra [3];
  logic [XLEN-1:0] rd [3];
  logic            raw, shaz;
  logic            accept, issue;
  logic [CW:0]     dec, up, dn;

  assign ra[0] = ent_q.ra1;
  assign ra[1] = ent_q.ra2;
  assign ra[2] = ent_q.ra3;

  // PC alias wins over bypass, bypass wins over the array
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      if (ra[i] == PCA)
        rd[i] = ent_q.pc;
      else if (wb_en && wb_addr == ra[i])
        rd[i] = wb_data;
      else
        rd[i] = rf_q[ra[i]];
    end
  end

  always_comb begin
    raw = 1'b0;
    dec = '0;
    for (int i = 0; i < 3; i++) begin
      dec = (CW+1)'(wb_en && wb_addr == ra[i])
          + (CW+1)'(kill_en && kill_addr == ra[i]);
      if (ent_q.srcuse[i] && ra[i] != PCA &&
          (CW+1)'(pend_q[ra[i]]) > dec)
        raw = 1'b1;
    end
  end

  assign shaz      = ent_q.we && pend_q[ent_q.wa] == PMAX;
  assign out_valid = reset && vld_q && !raw && !shaz && !flush;
  assign issue     = out_valid && out_ready;
  assign in_ready  = reset && (!vld_q || issue) && !flush;
  assign accept    = in_valid && in_ready;

  assign out_instr   = ent_q.instr;
  assign out_pcplus8 = ent_q.pc;
  assign out_rd1     = rd[0];
  assign out_rd2     = rd[1];
  assign out_rd3     = rd[2];

  always_comb begin
    vld_d = vld_q;
    ent_d = ent_q;
    if (accept) begin
      vld_d        = 1'b1;
      ent_d.instr  = in_instr;
      ent_d.pc     = in_pcplus8;
      ent_d.ra1    = in_ra1;
      ent_d.ra2    = in_ra2;
      ent_d.ra3    = in_ra3;
      ent_d.srcuse = in_use;
      ent_d.wa     = in_wa;
      ent_d.we     = in_we;
    end else if (flush || issue) begin
      vld_d = 1'b0;
    end
  end

  // Deltas are summed, then clamped at zero
  always_comb begin
    up = '0;
    dn = '0;
    for (int r = 0; r < NREG; r++) begin
      up = (CW+1)'(pend_q[r])
         + (CW+1)'(issue && ent_q.we && ent_q.wa != PCA &&
                   ent_q.wa == AW'(r));
      dn = (CW+1)'(wb_en && wb_addr == AW'(r))
         + (CW+1)'(kill_en && kill_addr == AW'(r));
      pend_d[r] = (up > dn) ? CW'(up - dn) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_q <= 1'b0;
      ent_q <= '0;
      for (int r = 0; r < NREG; r++) begin
        pend_q[r] <= '0;
        rf_q[r]   <= '0;
      end
    end else begin
      vld_q <= vld_d;
      ent_q <= ent_d;
      for (int r = 0; r < NREG; r++)
        pend_q[r] <= pend_d[r];
      if (wb_en && wb_addr != PCA)
        rf_q[wb_addr] <= wb_data;
    end
  end

endmodule

// File: tb/tb_id_stage_sb.sv
// Directed bench for id_stage_sb: reset, RAW stall/bypass, PC reads,
// scoreboard saturation, flush, kill and combined scoreboard deltas.
module tb_id_stage_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_pcplus8;
  logic [3:0]  in_ra1, in_ra2, in_ra3, in_wa;
  logic [2:0]  in_use;
  logic        in_we;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_pcplus8;
  logic [31:0] out_rd1, out_rd2, out_rd3;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        kill_en;
  logic [3:0]  kill_addr;
  logic        flush;

  int npass = 0;
  int ntot  = 0;

  id_stage_sb dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pcplus8(in_pcplus8),
    .in_ra1(in_ra1), .in_ra2(in_ra2), .in_ra3(in_ra3),
    .in_use(in_use), .in_wa(in_wa), .in_we(in_we),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pcplus8(out_pcplus8),
    .out_rd1(out_rd1), .out_rd2(out_rd2), .out_rd3(out_rd3),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .kill_en(kill_en), .kill_addr(kill_addr),
    .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] ins, input logic [31:0] pc,
                      input logic [3:0] a1, input logic [3:0] a2,
                      input logic [3:0] a3, input logic [2:0] u,
                      input logic [3:0] w, input logic we);
    in_valid = 1'b1; in_instr = ins; in_pcplus8 = pc;
    in_ra1 = a1; in_ra2 = a2; in_ra3 = a3;
    in_use = u; in_wa = w; in_we = we;
  endtask

  task automatic drop();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; out_ready = 1'b1;
    load(32'hAAAA0001, 32'h8, 4'd3, 4'd0, 4'd0, 3'b001, 4'd0, 1'b0);
    tick(); #1;
    ntot++; if (in_ready !== 1'b0) $display("FAIL rst_ready1 got=%0b exp=0", in_ready); else npass++;
    ntot++; if (out_valid !== 1'b0) $display("FAIL rst_valid1 got=%0b exp=0", out_valid); else npass++;
    tick(); #1;
    ntot++; if (in_ready !== 1'b0) $display("FAIL rst_ready2 got=%0b exp=0", in_ready); else npass++;
    ntot++; if (out_valid !== 1'b0) $display("FAIL rst_valid2 got=%0b exp=0", out_valid); else npass++;
    reset = 1'b1; drop(); #1;
    ntot++; if (in_ready !== 1'b1) $display("FAIL rel_ready got=%0b exp=1", in_ready); else npass++;
    ntot++; if (out_instr !== 32'h0) $display("FAIL rst_instr got=%h exp=0", out_instr); else npass++;
    ntot++; if (out_pcplus8 !== 32'h0) $display("FAIL rst_pc got=%h exp=0", out_pcplus8); else npass++;
    load(32'hAAAA0002, 32'h10, 4'd3, 4'd0, 4'd0, 3'b001, 4'd0, 1'b0);
    tick(); drop(); #1;
    ntot++; if (out_valid !== 1'b1) $display("FAIL r3_valid got=%0b exp=1", out_valid); else npass++;
    ntot++; if (out_rd1 !== 32'h0) $display("FAIL r3_data got=%h exp=0", out_rd1); else npass++;
    tick();
  endtask

  task automatic test_back_to_back();
    load(32'hE0811002, 32'h100, 4'd0, 4'd0, 4'd0, 3'b000, 4'd1, 1'b1);
    tick(); #1;
    ntot++; if (out_valid !== 1'b1) $display("FAIL add_valid got=%0b exp=1", out_valid); else npass++;
    ntot++; if (out_instr !== 32'hE0811002) $display("FAIL add_instr got=%h exp=e0811002", out_instr); else npass++;
    load(32'hE0415003, 32'h104, 4'd1, 4'd0, 4'd0, 3'b001, 4'd5, 1'b0);
    tick(); drop(); #1;
    ntot++; if (out_valid !== 1'b0) $display("FAIL sub_stall1 got=%0b exp=0", out_valid); else npass++;
    ntot++; if (out_instr !== 32'hE0415003) $display("FAIL sub_instr got=%h exp=e0415003", out_instr); else npass++;
    tick(); #1;
    ntot++; if (out_valid !== 1'b0) $display("FAIL sub_stall2 got=%0b exp=0", out_valid); else npass++;
    wb_en = 1'b1; wb_addr = 4'd1; wb_data = 32'h1234; #1;
    ntot++; if (out_valid !== 1'b1) $display("FAIL sub_release got=%0b exp=1", out_valid); else npass++;
    ntot++; if (out_rd1 !== 32'h1234) $display("FAIL sub_bypass got=%h exp=1234", out_rd1); else npass++;
    tick(); wb_en = 1'b0; #1;
    ntot++; if (out_valid !== 1'b0) $display("FAIL b2b_drain got=%0b exp=0", out_valid); else npass++;
    load(32'h11110001, 32'h108, 4'd1, 4'd0, 4'd0, 3'b001, 4'd0, 1'b0);
    tick(); drop(); #1;
    ntot++; if (out_rd1 !== 32'h1234) $display("FAIL r1_written got=%h exp=1234", out_rd1); else npass++;
    tick();
  endtask

  task automatic test_pc_read();
    load(32'h22220001, 32'h108, 4'd15, 4'd0, 4'd1, 3'b101, 4'd0, 1'b0);
    tick(); drop();
    wb_en = 1'b1; wb_addr = 4'd15; wb_data = 32'hDEAD; #1;
    ntot++; if (out_valid !== 1'b1) $display("FAIL pc_valid got=%0b exp=1", out_valid); else npass++;
    ntot++; if (out_rd1 !== 32'h108) $display("FAIL pc_rd1 got=%h exp=108", out_rd1); else npass++;
    ntot++; if (out_rd3 !== 32'h1234) $display("FAIL pc_rd3 got=%h exp=1234", out_rd3); else npass++;
    tick(); wb_en = 1'b0;
    load(32'h22220002, 32'h200, 4'd0, 4'd15, 4'd0, 3'b010, 4'd0, 1'b0);
    tick(); drop(); #1;
    ntot++; if (out_valid !== 1'b1) $display("FAIL pc2_valid got=%0b exp=1", out_valid); else npass++;
    ntot++; if (out_rd2 !== 32'h200) $display("FAIL pc2_rd2 got=%h exp=200", out_rd2); else npass++;
    tick();
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 4; k++) begin
      load(32'h33330000 + k, 32'h400 + 4*k, 4'd0, 4'd0, 4'd0, 3'b000, 4'd2, 1'b1);
      tick();
      if (k < 3) begin
        #1;
        ntot++; if (out_valid !== 1'b1) $display("FAIL sat_issue%0d got=%0b exp=1", k, out_valid); else npass++;
      end
    end
    drop(); #1;
    ntot++; if (out_valid !== 1'b0) $display("FAIL sat_stall got=%0b exp=0", out_valid); else npass++;
    tick(); #1;
    ntot++; if (out_valid !== 1'b0) $display("FAIL sat_stall2 got=%0b exp=0", out_valid); else npass++;
    wb_en = 1'b1; wb_addr = 4'd2; wb_data = 32'h22; #1;
    ntot++; if (out_valid !== 1'b0) $display("FAIL sat_wbcyc got=%0b exp=0", out_valid); else npass++;
    tick(); wb_en = 1'b0; #1;
    ntot++; if (out_valid !== 1'b1) $display("FAIL sat_release got=%0b exp=1", out_valid); else npass++;
    ntot++; if (out_instr !== 32'h33330003) $display("FAIL sat_instr got=%h exp=33330003", out_instr); else npass++;
    load(32'h33330004, 32'h410, 4'd0, 4'd0, 4'd0, 3'b000, 4'd2, 1'b1);
    tick(); drop(); #1;
    ntot++; if (out_valid !== 1'b0) $display("FAIL sat_refill got=%0b exp=0", out_valid); else npass++;
    flush = 1'b1;
    tick(); flush = 1'b0;
  endtask

  task automatic test_flush_kill();
    out_ready = 1'b0;
    load(32'h44440001, 32'h500, 4'd0, 4'd0, 4'd0, 3'b000, 4'd6, 1'b1);
    tick(); drop(); #1;
    ntot++; if (out_valid !== 1'b1) $display("FAIL fl_held got=%0b exp=1", out_valid); else npass++;
    tick(); #1;
    ntot++; if (out_instr !== 32'h44440001) $display("FAIL fl_stable got=%h exp=44440001", out_instr); else npass++;
    flush = 1'b1; out_ready = 1'b1;
    load(32'h44440002, 32'h504, 4'd0, 4'd0, 4'd0, 3'b000, 4'd0, 1'b0); #1;
    ntot++; if (out_valid !== 1'b0) $display("FAIL fl_noissue got=%0b exp=0", out_valid); else npass++;
    ntot++; if (in_ready !== 1'b0) $display("FAIL fl_noload got=%0b exp=0", in_ready); else npass++;
    tick(); flush = 1'b0; drop(); #1;
    ntot++; if (out_valid !== 1'b0) $display("FAIL fl_empty got=%0b exp=0", out_valid); else npass++;
    load(32'h44440003, 32'h508, 4'd6, 4'd0, 4'd0, 3'b001, 4'd0, 1'b0);
    tick(); drop(); #1;
    ntot++; if (out_valid !== 1'b1) $display("FAIL fl_r6_free got=%0b exp=1", out_valid); else npass++;
    tick();
    load(32'h55550001, 32'h600, 4'd0, 4'd0, 4'd0, 3'b000, 4'd1, 1'b1);
    tick();
    load(32'h55550002, 32'h604, 4'd1, 4'd0, 4'd0, 3'b001, 4'd7, 1'b0);
    tick(); drop(); #1;
    ntot++; if (out_valid !== 1'b0) $display("FAIL kill_stall got=%0b exp=0", out_valid); else npass++;
    kill_en = 1'b1; kill_addr = 4'd1; #1;
    ntot++; if (out_valid !== 1'b1) $display("FAIL kill_release got=%0b exp=1", out_valid); else npass++;
    ntot++; if (out_rd1 !== 32'h1234) $display("FAIL kill_stale got=%h exp=1234", out_rd1); else npass++;
    tick(); kill_en = 1'b0; #1;
    ntot++; if (out_valid !== 1'b0) $display("FAIL kill_drain got=%0b exp=0", out_valid); else npass++;
  endtask

  task automatic test_simultaneous();
    for (int k = 0; k < 3; k++) begin
      load(32'h66660000 + k, 32'h700 + 4*k, 4'd0, 4'd0, 4'd0, 3'b000, 4'd4, 1'b1);
      tick();
    end
    drop(); #1;
    ntot++; if (out_valid !== 1'b1) $display("FAIL sim_third got=%0b exp=1", out_valid); else npass++;
    wb_en = 1'b1; wb_addr = 4'd4; wb_data = 32'h44;
    kill_en = 1'b1; kill_addr = 4'd4; #1;
    ntot++; if (out_valid !== 1'b1) $display("FAIL sim_issue got=%0b exp=1", out_valid); else npass++;
    tick(); wb_en = 1'b0; kill_en = 1'b0;
    load(32'h66660010, 32'h710, 4'd4, 4'd0, 4'd0, 3'b001, 4'd0, 1'b0);
    tick(); drop(); #1;
    ntot++; if (out_valid !== 1'b0) $display("FAIL sim_pend1 got=%0b exp=0", out_valid); else npass++;
    wb_en = 1'b1; wb_addr = 4'd4; wb_data = 32'h55; #1;
    ntot++; if (out_valid !== 1'b1) $display("FAIL sim_last_wb got=%0b exp=1", out_valid); else npass++;
    ntot++; if (out_rd1 !== 32'h55) $display("FAIL sim_bypass got=%h exp=55", out_rd1); else npass++;
    tick(); wb_en = 1'b0;
  endtask

  task automatic test_reset_midstall();
    out_ready = 1'b0;
    load(32'h77770001, 32'h800, 4'd0, 4'd0, 4'd0, 3'b000, 4'd8, 1'b1);
    tick(); drop(); #1;
    ntot++; if (out_valid !== 1'b1) $display("FAIL mrst_held got=%0b exp=1", out_valid); else npass++;
    reset = 1'b0; #1;
    ntot++; if (out_valid !== 1'b0) $display("FAIL mrst_low got=%0b exp=0", out_valid); else npass++;
    tick(); reset = 1'b1; out_ready = 1'b1; #1;
    ntot++; if (out_valid !== 1'b0) $display("FAIL mrst_drop got=%0b exp=0", out_valid); else npass++;
    ntot++; if (out_instr !== 32'h0) $display("FAIL mrst_instr got=%h exp=0", out_instr); else npass++;
    load(32'h77770002, 32'h804, 4'd1, 4'd2, 4'd4, 3'b111, 4'd0, 1'b0);
    tick(); drop(); #1;
    ntot++; if (out_valid !== 1'b1) $display("FAIL mrst_pendclr got=%0b exp=1", out_valid); else npass++;
    ntot++; if (out_rd1 !== 32'h0) $display("FAIL mrst_rfclr got=%h exp=0", out_rd1); else npass++;
    tick();
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_instr = '0; in_pcplus8 = '0;
    in_ra1 = '0; in_ra2 = '0; in_ra3 = '0; in_use = '0;
    in_wa = '0; in_we = 1'b0; out_ready = 1'b1;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    kill_en = 1'b0; kill_addr = '0; flush = 1'b0;
    test_reset();
    test_back_to_back();
    test_pc_read();
    test_saturation();
    test_flush_kill();
    test_simultaneous();
    test_reset_midstall();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/id_stage_sb.md
# id_stage_sb

Parametrised instruction-decode pipeline stage for the ARM pipeline. It holds a valid/ready-handshaked ID register, an NREG×XLEN register file with three read ports and PC-as-register reads, and write-through bypass from writeback. A per-register pending-write scoreboard stalls issue on RAW hazards. It sits between fetch (with its combinational predecoder) and execute, and replaces the fixed 32-bit, stall-less decode register and regfile pairing.

## Interface
- XLEN, 32, datapath width
- NREG, 16, architectural registers; AW = $clog2(NREG)
- PC_IDX, 15, register index aliased to PC+8
- MAXPEND, 3, max in-flight writes per register; CW = $clog2(MAXPEND+1)

- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  fetch entry valid
- in_ready  out  1  ID register can accept
- in_instr  in  32  instruction word
- in_pcplus8  in  XLEN  PC+8 of the instruction
- in_ra1, in_ra2, in_ra3  in  AW each  source addresses (Rn, Rm/Rd, Rs) from predecoder
- in_use  in  3  bit i set = source i+1 is read
- in_wa  in  AW  destination address
- in_we  in  1  instruction writes in_wa
- out_valid  out  1  issue valid
- out_ready  in  1  execute accepts
- out_instr  out  32  registered instruction
- out_pcplus8  out  XLEN  registered PC+8
- out_rd1, out_rd2, out_rd3  out  XLEN each  operand data
- wb_en, wb_addr, wb_data  in  1/AW/XLEN  writeback port
- kill_en, kill_addr  in  1/AW  squash of one issued, not-yet-written destination
- flush  in  1  discard the ID register entry

## Operation
- Accept: in_valid && in_ready. Issue: out_valid && out_ready.
- in_ready = reset && (!id_valid || issue) && !flush.
- ID register loads all in_* fields on accept. On issue without accept, id_valid clears. flush clears id_valid and blocks the load in the same cycle.
- Operand read for source i:
  - If addr == PC_IDX, return the registered pcplus8.
  - Else if wb_en && wb_addr == addr, return wb_data (write-through).
  - Else return the regfile entry.
  - Unused sources still drive data and are don't-care.
- Regfile write: on wb_en at the clock edge. Writes to PC_IDX are ignored.
- Scoreboard: pend[r] is a CW-bit counter.
  - +1 on issue when registered we && wa != PC_IDX.
  - −1 on wb_en to r, and −1 on kill_en to r.
  - All applicable deltas sum in one cycle, so simultaneous issue+wb on the same r leaves it unchanged.
  - Result saturates at 0, so decrements at 0 are ignored and the regfile write still occurs.
- Hazard for used source i (addr != PC_IDX): pend[addr] minus that cycle's wb/kill decrements to addr is > 0.
  - A wb completing the last pending write therefore clears the hazard in the same cycle, and the data comes via bypass.
- Structural hazard: registered we && pend[wa] == MAXPEND.
- out_valid = reset && id_valid && !hazard && !flush.
- flush does not touch the scoreboard. Downstream squashes are reported through kill_*.

## Timing
- Reset (reset low at edge):
  - id_valid = 0, all pend = 0, all regfile entries = 0.
  - out_instr = 0, out_pcplus8 = 0.
  - While reset is low, in_ready = 0 and out_valid = 0.
  - Reset low mid-stall drops the held entry.
- Latency: an entry accepted at edge N can issue in cycle N+1 (1 cycle). Full throughput is 1 per cycle with no hazards.
- Operand outputs are combinational from current state plus the bypass. Issue samples them in the same cycle.
- The held entry and outputs remain stable while out_valid && !out_ready.
- out_valid may drop without a handshake only because of flush or reset. A hazard never appears on a held entry once out_valid is asserted, because pend only increments on this stage's issue.

## Test plan
- Reset: hold reset low 2 cycles with in_valid=1 -> in_ready=0, out_valid=0. After release, in_ready=1, and reading R3 returns 0.
- Back-to-back: ADD writes R1 (we), then SUB reads R1 -> SUB stalls (out_valid=0) until wb_en R1=0x1234. In that wb cycle, out_valid=1 and out_rd1=0x1234.
- PC read: ra1=15, pcplus8=0x108 -> out_rd1=0x108. A wb to R15 with 0xDEAD does not change a later R15 read.
- Saturation: issue 3 writes to R2 with no wb -> 4th write to R2 stalls. One wb to R2 -> it issues the next cycle, and pend[2] returns to 3.
- Flush/kill: entry held with out_ready=0, assert flush -> next cycle id_valid=0 and no issue. kill_en R1 with pend[1]=1 -> a dependent stalled reader of R1 is released and reads the stale regfile value.
- Simultaneous: issue writes R4 while wb_en R4 and kill_en R4 with pend[4]=2 -> pend[4]=1 next cycle.
